// File: rtl/iob_bus_sequencer.sv
// rtl/iob_bus_sequencer.sv - posted-write FIFO and 4-phase sequencer for CPU accesses to the IOB domain
module iob_bus_sequencer #(
  parameter int DEPTH = 2,
  parameter int AW    = 23
) (
  input  logic          CLK,
  input  logic          nRES,
  input  logic          BACT,
  input  logic          IOCS,
  input  logic          IOPWCS,
  input  logic          nWE,
  input  logic [AW-1:0] A,
  input  logic [1:0]    BE,
  input  logic [15:0]   D,
  output logic          CPUACK,
  output logic [15:0]   RD,
  output logic          IOREQ,
  output logic          IOWE,
  output logic [AW-1:0] IOA,
  output logic [1:0]    IOBE,
  output logic [15:0]   IOD,
  input  logic          IOACK,
  input  logic [15:0]   IORD,
  output logic          PostFull,
  output logic          PostEmpty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 2 + 16;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    C_IDLE,
    C_POST,
    C_DRAIN,
    C_DIRECT,
    C_DONE
  } cpu_state_t;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_REQ,
    IO_REL
  } io_state_t;

  cpu_state_t c_state, c_next;
  io_state_t  io_state, io_next;

  // Decode of the CPU cycle, frozen on the capture edge
  logic          cap_we;
  logic [AW-1:0] cap_a;
  logic [1:0]    cap_be;
  logic [15:0]   cap_d;

  // Posted-write storage; entries are {A, BE, D}
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Set while the IOB transfer in flight belongs to an unposted CPU cycle
  logic io_direct;

  logic fifo_full, fifo_empty;
  logic do_capture, do_push, do_launch, do_ack, rd_load;
  logic do_load_head, do_pop, io_done;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign PostFull   = fifo_full;
  assign PostEmpty  = fifo_empty;

  // A direct transfer finishes when the IOB side sees its acknowledge
  assign io_done = (io_state == IO_REQ) && IOACK && io_direct;

  // CPU FSM next state and control strobes
  always_comb begin
    c_next     = c_state;
    do_capture = 1'b0;
    do_push    = 1'b0;
    do_launch  = 1'b0;
    do_ack     = 1'b0;
    rd_load    = 1'b0;
    case (c_state)
      C_IDLE: begin
        if (BACT && IOCS) begin
          do_capture = 1'b1;
          c_next     = (IOPWCS && !nWE) ? C_POST : C_DRAIN;
        end
      end
      C_POST: begin
        if (!BACT) begin
          c_next = C_IDLE;
        end else if (!fifo_full) begin
          do_push = 1'b1;
          do_ack  = 1'b1;
          c_next  = C_DONE;
        end
      end
      C_DRAIN: begin
        // Unposted cycles go out only once every earlier posted write is done
        if (!BACT) begin
          c_next = C_IDLE;
        end else if (fifo_empty && (io_state == IO_IDLE)) begin
          do_launch = 1'b1;
          c_next    = C_DIRECT;
        end
      end
      C_DIRECT: begin
        // Dropping BACT here lets the IOB handshake finish on its own, unacknowledged
        if (!BACT) begin
          c_next = C_IDLE;
        end else if (io_done) begin
          do_ack  = 1'b1;
          rd_load = !cap_we;
          c_next  = C_DONE;
        end
      end
      C_DONE: begin
        if (!BACT) c_next = C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
  end

  // IOB FSM next state, head load and pop strobes
  always_comb begin
    io_next      = io_state;
    do_load_head = 1'b0;
    do_pop       = 1'b0;
    case (io_state)
      IO_IDLE: begin
        if (do_launch) begin
          io_next = IO_REQ;
        end else if (!fifo_empty) begin
          do_load_head = 1'b1;
          io_next      = IO_REQ;
        end
      end
      IO_REQ: begin
        if (IOACK) begin
          do_pop  = !io_direct;
          io_next = IO_REL;
        end
      end
      IO_REL: begin
        if (!IOACK) io_next = IO_IDLE;
      end
      default: io_next = IO_IDLE;
    endcase
  end

  // State registers for both FSMs
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      c_state  <= C_IDLE;
      io_state <= IO_IDLE;
    end else begin
      c_state  <= c_next;
      io_state <= io_next;
    end
  end

  // CPU-side capture, acknowledge pulse and read-data register
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      cap_we <= 1'b0;
      cap_a  <= '0;
      cap_be <= '0;
      cap_d  <= '0;
      CPUACK <= 1'b0;
      RD     <= '0;
    end else begin
      if (do_capture) begin
        cap_we <= !nWE;
        cap_a  <= A;
        cap_be <= BE;
        cap_d  <= D;
      end
      CPUACK <= do_ack;
      if (rd_load) RD <= IORD;
    end
  end

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= {cap_a, cap_be, cap_d};
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count unchanged
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // IOB request and transfer registers, held stable for the whole request phase
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      IOREQ     <= 1'b0;
      IOWE      <= 1'b0;
      IOA       <= '0;
      IOBE      <= '0;
      IOD       <= '0;
      io_direct <= 1'b0;
    end else begin
      IOREQ <= (io_next == IO_REQ);
      if (do_launch) begin
        IOWE      <= cap_we;
        IOA       <= cap_a;
        IOBE      <= cap_be;
        IOD       <= cap_d;
        io_direct <= 1'b1;
      end else if (do_load_head) begin
        IOWE             <= 1'b1;
        {IOA, IOBE, IOD} <= mem[rd_ptr];
        io_direct        <= 1'b0;
      end
    end
  end

endmodule
